axis_packet_fifo: RTL and testbench

Store-and-forward AXI-Stream packet FIFO. A packet becomes visible on the output only after its final beat (tlast) has been written, so downstream stages receive each packet as an unbroken burst with no upstream-induced bubbles. It sits directly upstream of the inter-packet gap enforcer: that stage's gap then sets the only idle cycles between packets. Packets too large for the buffer are dropped and flagged.

---
 rtl/axis_packet_fifo.sv | 172 +++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo
// Purpose  : Store-and-forward AXI-Stream packet FIFO. A packet is released
//            to the output only once its tlast beat has been written, so the
//            downstream side sees every packet as one unbroken burst.
//            Packets that can never fit in the buffer are discarded and
//            flagged with a one-cycle drop pulse.
// Ports    : clk, aresetn        - clock, async active-low reset
//            axis_i_*            - input stream (tready/tvalid/tlast/tdata)
//            axis_o_*            - output stream (tready/tvalid/tlast/tdata)
//            drop                - pulse when an oversize packet is discarded
//            pkt_count           - complete packets held (RAM + output stage)
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
    parameter int AXIS_BYTES = 1,
    parameter int DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      aresetn,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic                      drop,
    output logic [$clog2(DEPTH):0]    pkt_count
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [0:0] {
        ST_WRITE = 1'b0,
        ST_DROP  = 1'b1
    } wr_state_t;

    wr_state_t      state;
    logic [DW:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  wr_commit;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  occupancy;
    logic           running;
    logic           full;
    logic           wr_fire;
    logic           mem_we;
    logic           commit;
    logic           oversize;

    logic [DW:0]    stage [2];
    logic           stage_wsel;
    logic           stage_rsel;
    logic [1:0]     stage_cnt;
    logic           rd_fire;
    logic           pop;
    logic           pkt_dec;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign occupancy     = wr_ptr - rd_ptr;
    assign full          = (occupancy == DEPTH_P);
    // running keeps tready low while reset is held and releases it on the
    // first clock after deassertion.
    assign axis_i_tready = running && ((state == ST_DROP) || !full);
    assign wr_fire       = axis_i_tvalid && axis_i_tready;
    assign mem_we        = wr_fire && (state == ST_WRITE);
    assign commit        = mem_we && axis_i_tlast;
    // Buffer full of nothing but the packet in progress: it can never fit.
    assign oversize      = (state == ST_WRITE) && full && (wr_commit == rd_ptr);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= {axis_i_tlast, axis_i_tdata};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            running   <= 1'b0;
            state     <= ST_WRITE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            drop      <= 1'b0;
        end else begin
            running <= 1'b1;
            drop    <= 1'b0;
            case (state)
                ST_WRITE: begin
                    if (mem_we) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (axis_i_tlast) begin
                            wr_commit <= wr_ptr + 1'b1;
                        end
                    end else if (oversize) begin
                        // Discard the partial packet and swallow its tail.
                        wr_ptr <= wr_commit;
                        state  <= ST_DROP;
                        drop   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (wr_fire && axis_i_tlast) begin
                        state <= ST_WRITE;
                    end
                end
                default: state <= ST_WRITE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read side: synchronous RAM read straight into a 2-entry output stage.
    // Fetching only while the stage has a free slot keeps the RAM read
    // independent of axis_o_tready; two entries still give 1 beat/cycle.
    // ------------------------------------------------------------------
    assign pop     = (stage_cnt != 2'd0) && axis_o_tready;
    assign rd_fire = (rd_ptr != wr_commit) && (stage_cnt != 2'd2);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr     <= '0;
            stage[0]   <= '0;
            stage[1]   <= '0;
            stage_wsel <= 1'b0;
            stage_rsel <= 1'b0;
            stage_cnt  <= 2'd0;
        end else begin
            if (rd_fire) begin
                stage[stage_wsel] <= mem[rd_ptr[AW-1:0]];
                stage_wsel        <= ~stage_wsel;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (pop) begin
                stage_rsel <= ~stage_rsel;
            end
            case ({rd_fire, pop})
                2'b10:   stage_cnt <= stage_cnt + 2'd1;
                2'b01:   stage_cnt <= stage_cnt - 2'd1;
                default: stage_cnt <= stage_cnt;
            endcase
        end
    end

    assign axis_o_tvalid                = (stage_cnt != 2'd0);
    assign {axis_o_tlast, axis_o_tdata} = stage[stage_rsel];

    // ------------------------------------------------------------------
    // Complete-packet counter
    // ------------------------------------------------------------------
    assign pkt_dec = pop && axis_o_tlast;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else begin
            case ({commit, pkt_dec})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_fifo
// Purpose  : Self-checking bench for axis_packet_fifo (DEPTH=8, 1 byte).
//            A packet-level reference model (queues of beats, packets longer
//            than DEPTH vanish) predicts every output beat and pkt_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       axis_i_tready;
    logic       axis_i_tvalid = 1'b0;
    logic       axis_i_tlast = 1'b0;
    logic [7:0] axis_i_tdata = 8'h00;
    logic       axis_o_tready = 1'b0;
    logic       axis_o_tvalid;
    logic       axis_o_tlast;
    logic [7:0] axis_o_tdata;
    logic       drop;
    logic [3:0] pkt_count;

    axis_packet_fifo #(.AXIS_BYTES(1), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .axis_i_tready (axis_i_tready),
        .axis_i_tvalid (axis_i_tvalid),
        .axis_i_tlast  (axis_i_tlast),
        .axis_i_tdata  (axis_i_tdata),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tlast  (axis_o_tlast),
        .axis_o_tdata  (axis_o_tdata),
        .drop          (drop),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [8:0] src_q[$];   // beats still to be offered {tlast, data}
    logic [8:0] cur_q[$];   // beats of the packet currently being accepted
    logic [8:0] exp_q[$];   // committed beats expected on the output
    int  model_pkts = 0;
    int  drops_seen = 0;
    int  n_assert = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  vprob = 100;
    int  rprob = 100;
    int  lat_k = 0;
    int  acc_cnt = 0;
    int  out_cnt = 0;
    int  seq = 0;
    bit  lat_req = 0;
    bit  lat_on = 0;
    bit  b2b_en = 0;
    bit  hold_valid = 0;
    bit  prev_stall = 0;
    bit  prev_fire = 0;
    bit  prev_fire_mid = 0;
    logic [8:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        src_q.delete();
        cur_q.delete();
        exp_q.delete();
        model_pkts    = 0;
        hold_valid    = 0;
        prev_stall    = 0;
        prev_fire     = 0;
        prev_fire_mid = 0;
        lat_on        = 0;
        lat_req       = 0;
    endtask

    // One clock: check outputs at the falling edge, then drive the next
    // inputs and advance the model by the handshakes that will occur.
    task automatic step();
        logic ov, ol, ir, dr, in_fire, out_fire;
        logic [7:0] od;
        logic [3:0] pc;
        logic [8:0] b;
        @(negedge clk);
        cyc++;
        ov = axis_o_tvalid; ol = axis_o_tlast; od = axis_o_tdata;
        ir = axis_i_tready; dr = drop;         pc = pkt_count;
        if (dr) drops_seen++;
        chk("pkt_count", 32'(pc), 32'(model_pkts));
        if (ov) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(ov), 32'(0));
            else                   chk("out_beat", 32'({ol, od}), 32'(exp_q[0]));
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(ov), 32'(1));
            chk("stall_hold", 32'({ol, od}), 32'(prev_beat));
        end
        if (prev_fire_mid) chk("in_packet_gap", 32'(ov), 32'(1));
        if (b2b_en && prev_fire && exp_q.size() != 0) chk("b2b_gap", 32'(ov), 32'(1));
        if (lat_on && cyc == lat_k + 1) chk("latency_n1", 32'(ov), 32'(0));
        if (lat_on && cyc == lat_k + 2) begin
            chk("latency_n2", 32'(ov), 32'(1));
            lat_on = 0;
        end

        if (!hold_valid)
            axis_i_tvalid = (src_q.size() != 0) && ($urandom_range(0, 99) < vprob);
        if (axis_i_tvalid) {axis_i_tlast, axis_i_tdata} = src_q[0];
        else               {axis_i_tlast, axis_i_tdata} = 9'h000;
        axis_o_tready = ($urandom_range(0, 99) < rprob);

        in_fire    = axis_i_tvalid && ir;
        out_fire   = ov && axis_o_tready;
        hold_valid = axis_i_tvalid && !ir;

        if (out_fire && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            out_cnt++;
            if (b[8]) model_pkts--;
        end
        if (in_fire) begin
            b = src_q.pop_front();
            acc_cnt++;
            cur_q.push_back(b);
            if (b[8]) begin
                if (lat_req) begin
                    lat_req = 0;
                    lat_on  = 1;
                    lat_k   = cyc;
                end
                if (cur_q.size() <= DEPTH) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    model_pkts++;
                end
                cur_q.delete();
            end
        end
        prev_stall    = ov && !axis_o_tready;
        prev_beat     = {ol, od};
        prev_fire     = out_fire;
        prev_fire_mid = out_fire && !ol;
    endtask

    task automatic push_pkt(input int len, input bit counting);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = counting ? 8'(seq) : 8'($urandom);
            seq++;
            src_q.push_back({(i == len - 1), d});
        end
    endtask

    task automatic send_all(input int budget);
        int n = 0;
        while (src_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("send_timeout", 32'(src_q.size()), 32'(0));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(src_q.size() + exp_q.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(axis_o_tvalid), 32'(0));
        chk({tag, "_tlast"}, 32'(axis_o_tlast), 32'(0));
        chk({tag, "_tdata"}, 32'(axis_o_tdata), 32'(0));
        chk({tag, "_drop"}, 32'(drop), 32'(0));
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(0));
        chk({tag, "_tready"}, 32'(axis_i_tready), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- power-on reset ----------------
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        aresetn = 1'b1;
        @(negedge clk);
        chk("tready_after_por", 32'(axis_i_tready), 32'(1));

        // ---------------- basic: 3, 1, 5 beats, output held ----------------
        vprob = 100; rprob = 0; lat_req = 1; seq = 0;
        push_pkt(3, 1); push_pkt(1, 1); push_pkt(5, 1);
        send_all(100);
        repeat (4) step();
        chk("pkt_peak", 32'(pkt_count), 32'(3));
        rprob = 100; b2b_en = 1;
        drain(100);
        b2b_en = 0;

        // ---------------- store-and-forward with mid-packet gap ----------------
        lat_req = 1;
        src_q.push_back({1'b0, 8'hA0});
        src_q.push_back({1'b0, 8'hA1});
        send_all(20);
        repeat (10) step();
        src_q.push_back({1'b0, 8'hA2});
        src_q.push_back({1'b1, 8'hA3});
        drain(50);

        // ---------------- oversize: 12 then 2 beats ----------------
        drops_seen = 0;
        push_pkt(12, 0); push_pkt(2, 0);
        drain(200);
        chk("drop_count_12", 32'(drops_seen), 32'(1));
        // exactly DEPTH is kept, DEPTH+1 is dropped
        rprob = 40;
        push_pkt(DEPTH, 0); push_pkt(DEPTH + 1, 0); push_pkt(3, 0);
        drain(500);
        chk("drop_count_bound", 32'(drops_seen), 32'(2));

        // ---------------- full: RAM plus 2-entry output stage ----------------
        rprob = 0; vprob = 100; acc_cnt = 0;
        push_pkt(4, 0); push_pkt(4, 0); push_pkt(4, 0);
        repeat (20) step();
        chk("full_tready", 32'(axis_i_tready), 32'(0));
        chk("full_accepted", 32'(acc_cnt), 32'(DEPTH + 2));
        chk("full_no_drop", 32'(drops_seen), 32'(2));
        rprob = 50;
        drain(200);
        for (int p = 0; p < 50; p++) push_pkt(4, 0);
        drain(3000);

        // ---------------- random backpressure: 100 packets ----------------
        vprob = 50; rprob = 50;
        for (int p = 0; p < 100; p++) push_pkt(int'($urandom_range(1, 8)), 0);
        drain(6000);
        chk("random_no_drop", 32'(drops_seen), 32'(2));

        // ---------------- reset mid-operation ----------------
        vprob = 100; rprob = 100; out_cnt = 0;
        push_pkt(5, 0);
        src_q.push_back({1'b0, 8'h11});
        src_q.push_back({1'b0, 8'h22});
        begin
            int n = 0;
            while (out_cnt < 2 && n < 50) begin
                step();
                n++;
            end
        end
        chk("pre_reset_valid", 32'(axis_o_tvalid), 32'(1));
        #1 aresetn = 1'b0;
        #1 check_reset_outputs("async_rst");
        axis_i_tvalid = 1'b0; axis_o_tready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_outputs("held_rst");
        aresetn = 1'b1;
        @(negedge clk);
        chk("tready_after_rst", 32'(axis_i_tready), 32'(1));
        out_cnt = 0; rprob = 100;
        push_pkt(3, 0);
        drain(50);
        repeat (5) step();
        chk("post_reset_beats", 32'(out_cnt), 32'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
